// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the shared-ALU arbiter: ALU control codes and FSM states.
// The ALU decoder imports this package so every code has a single definition.
package alu_share_arbiter_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_LUI   = 4'd10,
    ALU_AUIPC = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic alu_op_defined(input logic [ALU_OP_W-1:0] op);
    return (op <= 4'd11);
  endfunction

endpackage

// File: rtl/alu_exec_core.sv
// Purely combinational RV32I ALU: op/a/b -> result plus an undefined-op flag.
// Reusable by the single-cycle core as well as the shared arbiter.
module alu_exec_core
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     result,
  output logic                err
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  sh_s;
  logic [XLEN-1:0] sum_s;

  assign sh_s  = b[SHW-1:0];
  assign sum_s = a + b;

  // Operation select; undefined codes yield zero and raise err
  always_comb begin
    result = {XLEN{1'b0}};
    err    = 1'b0;
    case (alu_op_e'(op))
      ALU_ADD:   result = sum_s;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:   result = a << sh_s;
      ALU_SRL:   result = a >> sh_s;
      ALU_SRA:   result = $signed(a) >>> sh_s;
      ALU_LUI:   result = b;
      ALU_AUIPC: result = sum_s;
      default: begin
        result = {XLEN{1'b0}};
        err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the execute stage (port 0) and a debug/CSR helper (port 1).
// Request is latched, executed for one cycle, and the result held until accepted.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid0,
  input  logic                req_valid1,
  output logic                req_ready0,
  output logic                req_ready1,
  input  logic [ALU_OP_W-1:0] req_op0,
  input  logic [ALU_OP_W-1:0] req_op1,
  input  logic [XLEN-1:0]     req_a0,
  input  logic [XLEN-1:0]     req_a1,
  input  logic [XLEN-1:0]     req_b0,
  input  logic [XLEN-1:0]     req_b1,
  output logic                rsp_valid0,
  output logic                rsp_valid1,
  input  logic                rsp_ready0,
  input  logic                rsp_ready1,
  output logic [XLEN-1:0]     rsp_result,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic                busy
);

  state_e              state_r;
  state_e              state_next_s;
  logic                last_grant_r;
  logic                grant_r;
  logic [ALU_OP_W-1:0] op_r;
  logic [XLEN-1:0]     a_r;
  logic [XLEN-1:0]     b_r;
  logic [XLEN-1:0]     result_r;
  logic                zero_r;
  logic                err_r;
  logic                rsp_valid0_r;
  logic                rsp_valid1_r;
  logic                win0_s;
  logic                win1_s;
  logic                accept_s;
  logic                rsp_take_s;
  logic [XLEN-1:0]     exec_result_s;
  logic                exec_err_s;

  alu_exec_core #(
    .XLEN (XLEN)
  ) u_exec (
    .op     (op_r),
    .a      (a_r),
    .b      (b_r),
    .result (exec_result_s),
    .err    (exec_err_s)
  );

  // Grant winner; on contention the port that was not granted last goes first
  always_comb begin
    win0_s = 1'b0;
    win1_s = 1'b0;
    if (req_valid0 && req_valid1) begin
      if (FIXED_PRIO || last_grant_r) begin
        win0_s = 1'b1;
      end else begin
        win1_s = 1'b1;
      end
    end else begin
      win0_s = req_valid0;
      win1_s = req_valid1;
    end
  end

  assign rsp_take_s = grant_r ? rsp_ready1 : rsp_ready0;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and request-ready outputs
  always_comb begin
    state_next_s = state_r;
    req_ready0   = 1'b0;
    req_ready1   = 1'b0;
    accept_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        req_ready0 = win0_s;
        req_ready1 = win1_s;
        if (win0_s || win1_s) begin
          accept_s     = 1'b1;
          state_next_s = S_EXEC;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_EXEC: state_next_s = S_RESP;
      S_RESP: begin
        if (rsp_take_s) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_RESP;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Request capture and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      op_r         <= {ALU_OP_W{1'b0}};
      a_r          <= {XLEN{1'b0}};
      b_r          <= {XLEN{1'b0}};
      result_r     <= {XLEN{1'b0}};
      zero_r       <= 1'b0;
      err_r        <= 1'b0;
      rsp_valid0_r <= 1'b0;
      rsp_valid1_r <= 1'b0;
    end else begin
      if (accept_s) begin
        op_r         <= win1_s ? req_op1 : req_op0;
        a_r          <= win1_s ? req_a1 : req_a0;
        b_r          <= win1_s ? req_b1 : req_b0;
        grant_r      <= win1_s;
        last_grant_r <= win1_s;
      end
      if (state_r == S_EXEC) begin
        result_r     <= exec_result_s;
        zero_r       <= (exec_result_s == {XLEN{1'b0}});
        err_r        <= exec_err_s;
        rsp_valid0_r <= ~grant_r;
        rsp_valid1_r <= grant_r;
      end else if ((state_r == S_RESP) && rsp_take_s) begin
        rsp_valid0_r <= 1'b0;
        rsp_valid1_r <= 1'b0;
      end
    end
  end

  assign rsp_valid0 = rsp_valid0_r;
  assign rsp_valid1 = rsp_valid1_r;
  assign rsp_result = result_r;
  assign rsp_zero   = zero_r;
  assign rsp_err    = err_r;
  assign busy       = (state_r != S_IDLE);

endmodule
